weightmemory_external_loader: RTL and testbench

WEIGHTMEMORY_EXTERNAL_LOADER -- requirements
Module: weightmemory_external_loader

---
 rtl/weightmemory_external_loader.sv | 148 ++++++++++++++
 tb/tb_weightmemory_external_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weightmemory_external_loader.sv
// Burst loader between a word stream and an external weight memory: write bursts pass
// stream words straight to memory, readback bursts fetch words into a 2-entry output FIFO.
module weightmemory_external_loader #(
  parameter  int PHYSICALBITSPERWORD = 104,
  parameter  int BANKDEPTH           = 1024,
  localparam int ADDRW               = $clog2(BANKDEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           mode_i,
  input  logic [ADDRW-1:0]               base_addr_i,
  input  logic [ADDRW:0]                 len_i,
  output logic                           busy_o,
  output logic                           done_o,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [PHYSICALBITSPERWORD-1:0] in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [PHYSICALBITSPERWORD-1:0] out_data_o,
  output logic                           external_req_o,
  output logic                           external_we_o,
  output logic [ADDRW-1:0]               external_addr_o,
  output logic [PHYSICALBITSPERWORD-1:0] external_wdata_o,
  input  logic [PHYSICALBITSPERWORD-1:0] external_weights_i,
  input  logic                           external_valid_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                         state, state_nx;
  logic [ADDRW-1:0]               base;
  logic [ADDRW:0]                 len, count, pops;
  logic                           outstanding;
  logic [1:0]                     fifo_cnt;
  logic                           rd_ptr, wr_ptr;
  logic [PHYSICALBITSPERWORD-1:0] fifo_mem [2];
  logic                           done_q, done_nx;
  logic                           issue_wr, issue_rd, ready;
  logic                           push, pop, last;
  logic [ADDRW-1:0]               addr_cur;
  logic [2:0]                     occupancy;

  // Truncation to ADDRW bits gives the modulo-BANKDEPTH wrap.
  assign addr_cur  = base + count[ADDRW-1:0];
  assign last      = (count == len - (ADDRW+1)'(1));
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, outstanding};
  assign push      = external_valid_i & outstanding;
  assign pop       = out_valid_o & out_ready_i;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) done_nx  = 1'b1;
          else             state_nx = mode_i ? READ : WRITE;
        end
      end
      WRITE: begin
        ready = 1'b1;
        if (in_valid_i) begin
          issue_wr = 1'b1;
          if (last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      READ: begin
        // Only issue when the returning word is guaranteed a FIFO slot.
        if (occupancy < 3'd2) begin
          issue_rd = 1'b1;
          if (last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!outstanding && fifo_cnt == 2'd0 && pops == len) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      base        <= '0;
      len         <= '0;
      count       <= '0;
      pops        <= '0;
      outstanding <= 1'b0;
    end else begin
      state       <= state_nx;
      done_q      <= done_nx;
      outstanding <= issue_rd;
      if (state == IDLE && start_i && len_i != '0) begin
        base  <= base_addr_i;
        len   <= len_i;
        count <= '0;
        pops  <= '0;
      end else begin
        if (issue_wr || issue_rd) count <= count + (ADDRW+1)'(1);
        if (pop)                  pops  <= pops + (ADDRW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt    <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= external_weights_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign busy_o           = (state != IDLE);
  assign done_o           = done_q;
  assign in_ready_o       = ready;
  assign external_req_o   = issue_wr | issue_rd;
  assign external_we_o    = issue_wr;
  assign external_addr_o  = external_req_o ? addr_cur : '0;
  assign external_wdata_o = issue_wr ? in_data_i : '0;
  assign out_valid_o      = (fifo_cnt != 2'd0);
  assign out_data_o       = out_valid_o ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_weightmemory_external_loader.sv
// Directed bench for weightmemory_external_loader: write/read bursts, backpressure,
// no-op, ignored start and mid-burst reset against a simple one-cycle memory model.
module tb_weightmemory_external_loader;
  localparam int W  = 104;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i, mode_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   len_i;
  logic          busy_o, done_o;
  logic          in_valid_i, in_ready_o;
  logic [W-1:0]  in_data_i;
  logic          out_valid_o, out_ready_i;
  logic [W-1:0]  out_data_o;
  logic          external_req_o, external_we_o;
  logic [AW-1:0] external_addr_o;
  logic [W-1:0]  external_wdata_o;
  logic [W-1:0]  external_weights_i;
  logic          external_valid_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cyc = 0;
  int bad_req = 0;
  logic [AW-1:0] waddr[$];
  logic [W-1:0]  wdat[$];
  int            wcyc[$];
  logic [AW-1:0] raddr[$];
  logic [W-1:0]  pops[$];
  int            popcyc[$];

  weightmemory_external_loader #(.PHYSICALBITSPERWORD(W), .BANKDEPTH(1024)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .external_req_o(external_req_o), .external_we_o(external_we_o),
    .external_addr_o(external_addr_o), .external_wdata_o(external_wdata_o),
    .external_weights_i(external_weights_i), .external_valid_i(external_valid_i)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mdata(input logic [AW-1:0] a);
    return {16'hBEEF, 78'h0, a};
  endfunction

  function automatic logic [W-1:0] wword(input int i);
    return {24'hCAFE00, 48'h0, 32'(i + 32'h100)};
  endfunction

  // Memory model: read data returns one cycle after each read request.
  always @(posedge clk) begin
    external_valid_i   <= external_req_o & ~external_we_o;
    external_weights_i <= mdata(external_addr_o);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (external_req_o) begin
        if (!busy_o) bad_req++;
        if (external_we_o) begin
          waddr.push_back(external_addr_o);
          wdat.push_back(external_wdata_o);
          wcyc.push_back(cyc);
        end else raddr.push_back(external_addr_o);
      end
      if (out_valid_o && out_ready_i) begin
        pops.push_back(out_data_o);
        popcyc.push_back(cyc);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_o) busy_cyc++;
    end
  end

  task automatic clear_logs();
    waddr.delete(); wdat.delete(); wcyc.delete();
    raddr.delete(); pops.delete(); popcyc.delete();
    done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic start_cmd(input logic m, input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = m; base_addr_i = b; len_i = l;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (done_cnt > base_cnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 1'b1; mode_i = 1'b0; base_addr_i = 10'h155; len_i = 11'd4;
    in_valid_i = 1'b1; in_data_i = wword(7); out_ready_i = 1'b1;
    #12;
    checks++;
    if ({busy_o, done_o, in_ready_o, out_valid_o, external_req_o, external_we_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000",
        {busy_o, done_o, in_ready_o, out_valid_o, external_req_o, external_we_o});
    end
    checks++;
    if (external_addr_o !== '0 || external_wdata_o !== '0 || out_data_o !== '0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h want 0",
        external_addr_o, external_wdata_o, out_data_o);
    end
    start_i = 1'b0; in_valid_i = 1'b0; len_i = '0;
    @(posedge clk); #3;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: busy %b done %b want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_write();
    int k = 0;
    bit ok;
    clear_logs();
    in_valid_i = 1'b1; in_data_i = wword(0);
    start_cmd(1'b0, 10'h3FE, 11'd4);
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (in_ready_o) k++;
      @(posedge clk); #1;
      in_data_i = wword(k);
    end
    in_valid_i = 1'b0;
    wait_done(0, 10, ok);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (waddr.size() != 4) begin
      errors++; $display("FAIL write_count: got %0d want 4", waddr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [AW-1:0] ea;
        ea = AW'(10'h3FE + i);
        checks++;
        if (waddr[i] !== ea || wdat[i] !== wword(i)) begin
          errors++; $display("FAIL write_beat%0d: addr %h data %h want %h %h",
            i, waddr[i], wdat[i], ea, wword(i));
        end
      end
      checks++;
      if (wcyc[3] != wcyc[0] + 3 || done_cyc != wcyc[3] + 1) begin
        errors++; $display("FAIL write_timing: cycles %0d..%0d done %0d want consecutive, done last+1",
          wcyc[0], wcyc[3], done_cyc);
      end
    end
    checks++;
    if (!ok || done_cnt != 1) begin
      errors++; $display("FAIL write_done: pulses %0d want 1", done_cnt);
    end
  endtask

  task automatic test_readback();
    bit ok;
    clear_logs();
    out_ready_i = 1'b1;
    start_cmd(1'b1, 10'h010, 11'd3);
    wait_done(0, 50, ok);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (!ok || done_cnt != 1) begin
      errors++; $display("FAIL read_done: pulses %0d want 1", done_cnt);
    end
    checks++;
    if (pops.size() != 3) begin
      errors++; $display("FAIL read_count: got %0d want 3", pops.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pops[i] !== mdata(AW'(10'h010 + i))) begin
          errors++; $display("FAIL read_word%0d: got %h want %h", i, pops[i], mdata(AW'(10'h010 + i)));
        end
      end
      checks++;
      if (done_cyc <= popcyc[2]) begin
        errors++; $display("FAIL read_done_order: done cycle %0d want after pop %0d", done_cyc, popcyc[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    out_ready_i = 1'b0;
    start_cmd(1'b1, 10'h020, 11'd5);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (raddr.size() != 2) begin
      errors++; $display("FAIL bp_reads: got %0d want 2", raddr.size());
    end
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== mdata(10'h020)) begin
      errors++; $display("FAIL bp_head: valid %b data %h want 1 %h", out_valid_o, out_data_o, mdata(10'h020));
    end
    out_ready_i = 1'b1;
    wait_done(0, 60, ok);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (!ok || done_cnt != 1 || pops.size() != 5) begin
      errors++; $display("FAIL bp_complete: done %0d pops %0d want 1 5", done_cnt, pops.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pops[i] !== mdata(AW'(10'h020 + i))) begin
          errors++; $display("FAIL bp_word%0d: got %h want %h", i, pops[i], mdata(AW'(10'h020 + i)));
        end
      end
    end
  endtask

  task automatic test_noop();
    clear_logs();
    start_cmd(1'b1, 10'h123, 11'd0);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL noop_done: done %b busy %b want 1 0", done_o, busy_o);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (done_cnt != 1 || busy_cyc != 0 || raddr.size() != 0 || waddr.size() != 0) begin
      errors++; $display("FAIL noop_quiet: done %0d busy %0d reqs %0d want 1 0 0",
        done_cnt, busy_cyc, raddr.size() + waddr.size());
    end
  endtask

  task automatic test_ignored_start();
    bit ok;
    clear_logs();
    out_ready_i = 1'b1;
    start_cmd(1'b1, 10'h100, 11'd3);
    start_cmd(1'b0, 10'h200, 11'd7);
    in_valid_i = 1'b1; in_data_i = wword(9);
    wait_done(0, 50, ok);
    in_valid_i = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (!ok || done_cnt != 1 || waddr.size() != 0 || raddr.size() != 3 || busy_o !== 1'b0) begin
      errors++; $display("FAIL ign_burst: done %0d writes %0d reads %0d busy %b want 1 0 3 0",
        done_cnt, waddr.size(), raddr.size(), busy_o);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pops[i] !== mdata(AW'(10'h100 + i))) begin
          errors++; $display("FAIL ign_word%0d: got %h want %h", i, pops[i], mdata(AW'(10'h100 + i)));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    out_ready_i = 1'b0;
    start_cmd(1'b1, 10'h040, 11'd6);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_prefill: out_valid %b want 1", out_valid_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, in_ready_o, out_valid_o, external_req_o, external_we_o} !== 6'b0 ||
        external_addr_o !== '0 || out_data_o !== '0 || external_wdata_o !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: busy %b valid %b req %b data %h want all 0",
        busy_o, out_valid_o, external_req_o, out_data_o);
    end
    repeat (2) @(posedge clk); #3;
    rst_ni = 1'b1;
    clear_logs();
    repeat (4) @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_cnt != 0 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_idle: busy %b done %0d valid %b want 0 0 0", busy_o, done_cnt, out_valid_o);
    end
    out_ready_i = 1'b1;
    start_cmd(1'b1, 10'h3FF, 11'd2);
    wait_done(0, 40, ok);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (!ok || done_cnt != 1 || pops.size() != 2) begin
      errors++; $display("FAIL rst_rerun: done %0d pops %0d want 1 2", done_cnt, pops.size());
    end else begin
      checks++;
      if (pops[0] !== mdata(10'h3FF) || pops[1] !== mdata(10'h000)) begin
        errors++; $display("FAIL rst_rerun_data: got %h %h want %h %h",
          pops[0], pops[1], mdata(10'h3FF), mdata(10'h000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_backpressure();
    test_noop();
    test_ignored_start();
    test_reset_mid();
    checks++;
    if (bad_req != 0) begin
      errors++; $display("FAIL req_outside_burst: got %0d want 0", bad_req);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
